// File: rtl/digit_display_mux_if.sv
// Bus between the ring-counter/value source and the 7-segment display multiplexer.
// The master drives select, load and value; the slave returns display drive and status.
interface digit_display_mux_if;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        load_ack;
  logic        sel_err;

  modport master (
    output A, B, C, D, load, value, dp_in, blank_lz,
    input  seg, dp, an, load_ack, sel_err
  );

  modport slave (
    input  A, B, C, D, load, value, dp_in, blank_lz,
    output seg, dp, an, load_ack, sel_err
  );
endinterface

// File: rtl/digit_display_mux.sv
// 4-digit multiplexed 7-segment driver fed by a one-hot ring counter (A = units).
// Values are double-buffered and only committed when the scan re-enters digit 0.
module digit_display_mux #(
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic                clk,
  input logic                reset,
  digit_display_mux_if.slave bus
);
  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES);

  logic [3:0]  w_sel_in;
  logic        w_sel_change;
  logic        w_commit;
  logic        w_sel_onehot;
  logic [6:0]  w_digit_seg [4];
  logic [6:0]  w_seg_sel;
  logic        w_dp_sel;

  logic [15:0] r_shadow;
  logic [15:0] r_active;
  logic [3:0]  r_dp_shadow;
  logic [3:0]  r_dp_active;
  logic        r_pending;
  logic [3:0]  r_sel_q;
  logic [3:0]  r_dead;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic [3:0]  r_an;
  logic        r_load_ack;
  logic        r_sel_err;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign w_sel_in     = {bus.D, bus.C, bus.B, bus.A};
  assign w_sel_change = (w_sel_in != r_sel_q);
  // Frame boundary: the scan enters digit 0 from anything else.
  assign w_commit     = (w_sel_in == 4'b0001) && (r_sel_q != 4'b0001);
  assign w_sel_onehot = (r_sel_q != 4'b0000) && ((r_sel_q & (r_sel_q - 4'd1)) == 4'b0000);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic w_blank;
      if (gi == 0) begin : g_units
        assign w_blank = 1'b0;
      end else begin : g_upper
        assign w_blank = bus.blank_lz && (r_active[15:4*gi] == '0);
      end
      assign w_digit_seg[gi] = w_blank ? 7'h00 : bcd_to_seg(r_active[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    w_seg_sel = 7'h00;
    w_dp_sel  = 1'b0;
    case (r_sel_q)
      4'b0001: begin w_seg_sel = w_digit_seg[0]; w_dp_sel = r_dp_active[0]; end
      4'b0010: begin w_seg_sel = w_digit_seg[1]; w_dp_sel = r_dp_active[1]; end
      4'b0100: begin w_seg_sel = w_digit_seg[2]; w_dp_sel = r_dp_active[2]; end
      4'b1000: begin w_seg_sel = w_digit_seg[3]; w_dp_sel = r_dp_active[3]; end
      default: ;
    endcase
  end

  // A load on the commit edge lands in the shadow after the old shadow has moved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow    <= 16'h0000;
      r_active    <= 16'h0000;
      r_dp_shadow <= 4'h0;
      r_dp_active <= 4'h0;
      r_pending   <= 1'b0;
      r_load_ack  <= 1'b0;
    end else begin
      r_load_ack <= w_commit && r_pending;
      if (w_commit && r_pending) begin
        r_active    <= r_shadow;
        r_dp_active <= r_dp_shadow;
      end
      if (bus.load) begin
        r_shadow    <= bus.value;
        r_dp_shadow <= bus.dp_in;
        r_pending   <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_q   <= 4'b0000;
      r_dead    <= 4'd0;
      r_seg     <= 7'h00;
      r_dp      <= 1'b0;
      r_an      <= 4'b0000;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_q <= w_sel_in;
      if (w_sel_change) begin
        r_dead <= DEAD_LOAD;
      end else if (r_dead != 4'd0) begin
        r_dead <= r_dead - 4'd1;
      end
      r_an      <= (r_dead == 4'd0 && w_sel_onehot) ? r_sel_q : 4'b0000;
      r_seg     <= w_seg_sel;
      r_dp      <= w_dp_sel;
      r_sel_err <= !w_sel_onehot;
    end
  end

  assign bus.seg      = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign bus.dp       = SEG_ACTIVE_LOW ? ~r_dp : r_dp;
  assign bus.an       = AN_ACTIVE_LOW ? ~r_an : r_an;
  assign bus.load_ack = r_load_ack;
  assign bus.sel_err  = r_sel_err;
endmodule

// File: tb/tb_digit_display_mux.sv
// Scoreboard bench for digit_display_mux: a timestamp-based reference model predicts
// every cycle's outputs; a monitor pops and compares one prediction per clock edge.
module tb_digit_display_mux;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digit_display_mux_if bus();

  digit_display_mux #(
    .DEAD_CYCLES   (DEAD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         edge_no;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ack;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Reference model state, as seen between clock edges
  logic [3:0]  m_sel;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_dpa, m_dps;
  logic        m_pending;
  int          last_change;
  int          edge_no = 0;
  logic [15:0] cur_val = 16'h0000;
  logic [3:0]  cur_dp = 4'h0;
  logic        cur_blz = 1'b0;

  function automatic logic [6:0] al(input logic [6:0] x);
    return ~x;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) == 0) v[4*i +: 4] = 4'd0;
      else v[4*i +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic model_reset();
    m_sel       = 4'b0000;
    m_active    = 16'h0000;
    m_shadow    = 16'h0000;
    m_dpa       = 4'h0;
    m_dps       = 4'h0;
    m_pending   = 1'b0;
    last_change = -1000;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end else begin
      $display("[TB] check %s = %h ok", name, got);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge, then advance.
  task automatic step(input logic [3:0] sel, input logic ld);
    exp_t        e;
    int          d;
    logic        onehot, an_on, blanked, commit;
    logic [15:0] upper;
    logic [6:0]  lit;
    logic        dlit;
    #2;
    {bus.D, bus.C, bus.B, bus.A} = sel;
    bus.load     = ld;
    bus.value    = cur_val;
    bus.dp_in    = cur_dp;
    bus.blank_lz = cur_blz;

    onehot = ($countones(m_sel) == 1);
    d = 0;
    for (int i = 0; i < 4; i++) if (m_sel[i]) d = i;
    lit  = 7'h00;
    dlit = 1'b0;
    if (onehot) begin
      upper   = m_active >> (4 * d);
      blanked = cur_blz && (d > 0) && (upper == 16'h0000);
      lit     = blanked ? 7'h00 : seg_lut[upper[3:0]];
      dlit    = m_dpa[d];
    end
    an_on    = onehot && (edge_no >= last_change + 1 + DEAD);
    commit   = (sel == 4'b0001) && (m_sel != 4'b0001);
    e.edge_no = edge_no;
    e.seg     = ~lit;
    e.dp      = ~dlit;
    e.an      = ~(an_on ? m_sel : 4'b0000);
    e.ack     = commit && m_pending;
    e.err     = !onehot;
    exp_q.push_back(e);

    if (commit && m_pending) begin
      m_active  = m_shadow;
      m_dpa     = m_dps;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_shadow  = cur_val;
      m_dps     = cur_dp;
      m_pending = 1'b1;
    end
    if (sel != m_sel) last_change = edge_no;
    m_sel = sel;
    edge_no++;
    @(posedge clk);
  endtask

  task automatic hold(input logic [3:0] sel, input int n);
    repeat (n) step(sel, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.seg !== e.seg || bus.dp !== e.dp || bus.an !== e.an ||
            bus.load_ack !== e.ack || bus.sel_err !== e.err) begin
          fails++;
          $display("FAIL scoreboard edge %0d: got seg=%h dp=%b an=%b ack=%b err=%b, expected seg=%h dp=%b an=%b ack=%b err=%b",
                   e.edge_no, bus.seg, bus.dp, bus.an, bus.load_ack, bus.sel_err,
                   e.seg, e.dp, e.an, e.ack, e.err);
        end else if (e.ack) begin
          $display("[TB] edge %0d load_ack, display committed", e.edge_no);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b0;
    {bus.D, bus.C, bus.B, bus.A} = 4'b0000;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;
    model_reset();

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.A     = i[0];
      bus.B     = ~i[0];
      bus.load  = 1'b1;
      bus.value = 16'($urandom);
      #1;
      chk("rst_seg", 16'(bus.seg), 16'h007F);
      chk("rst_an", 16'(bus.an), 16'h000F);
      chk("rst_dp_ack_err", 16'({bus.dp, bus.load_ack, bus.sel_err}), 16'h0004);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();

    hold(4'b0000, 3);
    #1 chk("post_rst_an", 16'(bus.an), 16'h000F);

    // Scan with dead-time
    cur_val = 16'h1234;
    step(4'b0001, 1'b1);
    hold(4'b0001, 3);
    hold(4'b0010, 4);
    hold(4'b0100, 4);
    hold(4'b1000, 4);
    step(4'b0001, 1'b0);
    #1 chk("t2_ack", 16'(bus.load_ack), 16'h0001);
    hold(4'b0001, 5);
    step(4'b0010, 1'b0);
    #1 chk("t2_an_old", 16'(bus.an), 16'h000E);
    step(4'b0010, 1'b0);
    #1 chk("t2_an_dead", 16'(bus.an), 16'h000F);
    hold(4'b0010, 2);
    #1 chk("t2_an_b", 16'(bus.an), 16'h000D);
    chk("t2_seg_3", 16'(bus.seg), 16'(al(7'h4F)));

    // Tear-free commit: new value loaded mid-frame
    cur_val = 16'h5678;
    step(4'b0010, 1'b1);
    hold(4'b0010, 2);
    hold(4'b0100, 6);
    #1 chk("t3_seg_c", 16'(bus.seg), 16'(al(7'h5B)));
    hold(4'b1000, 6);
    #1 chk("t3_seg_d", 16'(bus.seg), 16'(al(7'h06)));
    step(4'b0001, 1'b0);
    #1 chk("t3_ack", 16'(bus.load_ack), 16'h0001);
    hold(4'b0001, 4);
    #1 chk("t3_seg_8", 16'(bus.seg), 16'(al(7'h7F)));
    chk("t3_ack_once", 16'(bus.load_ack), 16'h0000);

    // Leading-zero blanking
    cur_val = 16'h0007;
    cur_dp  = 4'b0100;
    cur_blz = 1'b1;
    step(4'b0001, 1'b1);
    hold(4'b0010, 4);
    hold(4'b0100, 4);
    hold(4'b1000, 4);
    hold(4'b0001, 4);
    hold(4'b0010, 6);
    #1 chk("t4_d1_dark", 16'({bus.an, bus.seg, bus.dp}), 16'({4'b1101, 7'h7F, 1'b1}));
    hold(4'b0100, 6);
    #1 chk("t4_d2_dp", 16'({bus.an, bus.seg, bus.dp}), 16'({4'b1011, 7'h7F, 1'b0}));
    hold(4'b1000, 6);
    #1 chk("t4_d3_dark", 16'({bus.seg, bus.dp}), 16'({7'h7F, 1'b1}));
    hold(4'b0001, 6);
    #1 chk("t4_d0_7", 16'(bus.seg), 16'(al(7'h07)));
    cur_blz = 1'b0;
    hold(4'b0010, 6);
    #1 chk("t4_d1_zero", 16'(bus.seg), 16'(al(7'h3F)));

    // Invalid select
    hold(4'b0101, 3);
    hold(4'b0000, 3);
    #1 chk("t5_err", 16'({bus.sel_err, bus.an, bus.seg}), 16'({1'b1, 4'hF, 7'h7F}));
    hold(4'b0001, 2);
    #1 chk("t5_err_clr", 16'(bus.sel_err), 16'h0000);

    // Reset mid-frame with a pending value
    hold(4'b0010, 3);
    cur_val = 16'h4321;
    step(4'b0100, 1'b1);
    hold(4'b0100, 2);
    #3;
    reset = 1'b0;
    #1 chk("t6_async", 16'({bus.an, bus.seg, bus.dp, bus.load_ack}), 16'({4'hF, 7'h7F, 1'b1, 1'b0}));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    hold(4'b0001, 6);
    #1 chk("t6_zero", 16'({bus.seg, bus.load_ack}), 16'({al(7'h3F), 1'b0}));

    // Randomized ring scan with occasional bad selects, loads and blanking flips
    begin : random_phase
      int pos;
      pos = 0;
      for (int n = 0; n < 400; n++) begin
        int         h;
        logic [3:0] sel;
        logic       ld;
        h = $urandom_range(1, 6);
        if ($urandom_range(0, 19) == 0) begin
          sel = 4'($urandom_range(0, 15));
        end else begin
          sel = 4'b0001 << pos;
          pos = (pos + 1) % 4;
        end
        for (int k = 0; k < h; k++) begin
          ld = ($urandom_range(0, 7) == 0);
          if (ld) begin
            cur_val = rand_bcd();
            cur_dp  = 4'($urandom_range(0, 15));
          end
          if ($urandom_range(0, 15) == 0) cur_blz = ~cur_blz;
          step(sel, ld);
        end
      end
    end

    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
